// File: rtl/branch_compare_unit_if.sv
// rtl/branch_compare_unit_if.sv - request/result bundle of the branch compare unit
interface branch_compare_unit_if #(
    parameter int WIDTH     = 16,
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     X;
    logic [WIDTH-1:0]     Y;
    logic [2:0]           mode;
    logic [PC_WIDTH-1:0]  pc;
    logic [PC_WIDTH-1:0]  offset;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic                 taken;
    logic [PC_WIDTH-1:0]  target;
    logic                 nEq;
    logic                 lt;
    logic                 ltu;
    logic [CNT_WIDTH-1:0] taken_count;

    modport slave (
        input  in_valid, X, Y, mode, pc, offset, flush, out_ready,
        output in_ready, out_valid, taken, target, nEq, lt, ltu, taken_count
    );

    modport master (
        output in_valid, X, Y, mode, pc, offset, flush, out_ready,
        input  in_ready, out_valid, taken, target, nEq, lt, ltu, taken_count
    );
endinterface

// File: rtl/branch_compare_unit.sv
// rtl/branch_compare_unit.sv - two-stage branch condition resolver with target and taken counter
module branch_compare_unit #(
    parameter int WIDTH     = 16,
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_compare_unit_if.slave bus
);
    typedef enum logic [2:0] {
        MODE_BEQ  = 3'b000,
        MODE_BNE  = 3'b001,
        MODE_BLT  = 3'b010,
        MODE_BGE  = 3'b011,
        MODE_BLTU = 3'b100,
        MODE_BGEU = 3'b101
    } branch_mode_t;

    logic                 s1_valid;
    logic [WIDTH:0]       s1_diff;
    logic                 s1_xs;
    logic                 s1_ys;
    logic [2:0]           s1_mode;
    logic [PC_WIDTH-1:0]  s1_target;

    logic                 s2_valid;
    logic                 s2_taken;
    logic                 s2_neq;
    logic                 s2_lt;
    logic                 s2_ltu;
    logic [PC_WIDTH-1:0]  s2_target;
    logic [CNT_WIDTH-1:0] count;

    logic s2_free;
    logic s2_load;
    logic ready;
    logic accept;
    logic consume;
    logic d_neq;
    logic d_ltu;
    logic d_ovf;
    logic d_lt;
    logic d_taken;

    assign s2_free = !s2_valid || bus.out_ready;
    assign s2_load = s1_valid && s2_free;
    assign ready   = !s1_valid || s2_load;
    assign accept  = bus.in_valid && ready;
    assign consume = s2_valid && bus.out_ready;

    // Held low during reset so every output reads 0 while rst_n is asserted.
    assign bus.in_ready    = rst_n && ready;
    assign bus.out_valid   = s2_valid;
    assign bus.taken       = s2_taken;
    assign bus.target      = s2_target;
    assign bus.nEq         = s2_neq;
    assign bus.lt          = s2_lt;
    assign bus.ltu         = s2_ltu;
    assign bus.taken_count = count;

    always_comb begin
        d_neq   = |s1_diff[WIDTH-1:0];
        d_ltu   = s1_diff[WIDTH];
        // Signed overflow of X-Y: operands differ in sign and the result sign left X's.
        d_ovf   = (s1_xs != s1_ys) && (s1_diff[WIDTH-1] != s1_xs);
        d_lt    = s1_diff[WIDTH-1] ^ d_ovf;
        d_taken = 1'b0;
        case (s1_mode)
            MODE_BEQ:  d_taken = !d_neq;
            MODE_BNE:  d_taken = d_neq;
            MODE_BLT:  d_taken = d_lt;
            MODE_BGE:  d_taken = !d_lt;
            MODE_BLTU: d_taken = d_ltu;
            MODE_BGEU: d_taken = !d_ltu;
            default:   d_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_diff   <= '0;
            s1_xs     <= 1'b0;
            s1_ys     <= 1'b0;
            s1_mode   <= '0;
            s1_target <= '0;
        end else begin
            if (bus.flush) begin
                s1_valid <= 1'b0;
            end else if (ready) begin
                s1_valid <= bus.in_valid;
            end
            if (accept) begin
                s1_diff   <= {1'b0, bus.X} - {1'b0, bus.Y};
                s1_xs     <= bus.X[WIDTH-1];
                s1_ys     <= bus.Y[WIDTH-1];
                s1_mode   <= bus.mode;
                s1_target <= bus.pc + bus.offset;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_taken  <= 1'b0;
            s2_neq    <= 1'b0;
            s2_lt     <= 1'b0;
            s2_ltu    <= 1'b0;
            s2_target <= '0;
        end else begin
            if (bus.flush) begin
                s2_valid <= 1'b0;
            end else if (s2_free) begin
                s2_valid <= s1_valid;
            end
            if (s2_load) begin
                s2_taken  <= d_taken;
                s2_neq    <= d_neq;
                s2_lt     <= d_lt;
                s2_ltu    <= d_ltu;
                s2_target <= s1_target;
            end
        end
    end

    // A result consumed on a flush edge still counts: flush only kills in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (consume && s2_taken && (count != {CNT_WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_compare_unit.sv
// tb/tb_branch_compare_unit.sv - directed self-checking bench for branch_compare_unit
module tb_branch_compare_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_compare_unit_if #(.WIDTH(16), .PC_WIDTH(16), .CNT_WIDTH(8)) b ();
    branch_compare_unit_if #(.WIDTH(16), .PC_WIDTH(16), .CNT_WIDTH(3)) s ();

    branch_compare_unit #(.WIDTH(16), .PC_WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b.slave)
    );
    branch_compare_unit #(.WIDTH(16), .PC_WIDTH(16), .CNT_WIDTH(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(s.slave)
    );

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic [15:0] x, input logic [15:0] y, input logic [2:0] m,
                           input logic [15:0] pc, input logic [15:0] off);
        b.X = x; b.Y = y; b.mode = m; b.pc = pc; b.offset = off;
    endtask

    task automatic drive_s(input logic [15:0] x, input logic [15:0] y, input logic [2:0] m);
        s.X = x; s.Y = y; s.mode = m; s.pc = 16'h0; s.offset = 16'h0;
    endtask

    task automatic test_reset();
        b.in_valid = 0; b.flush = 0; b.out_ready = 0; drive_b(0, 0, 0, 0, 0);
        s.in_valid = 0; s.flush = 0; s.out_ready = 0; drive_s(0, 0, 0);
        rst_n = 0;
        repeat (2) step();
        tests++;
        if ({b.in_ready, b.out_valid, b.taken, b.target, b.nEq, b.lt, b.ltu, b.taken_count} !== 30'h0) begin
            fails++; $display("FAIL reset_outputs got=%0h exp=0", {b.in_ready, b.out_valid, b.taken, b.target, b.nEq, b.lt, b.ltu, b.taken_count});
        end
        @(negedge clk); rst_n = 1;
        step();
        tests++;
        if ({b.in_ready, b.out_valid, b.taken_count} !== {1'b1, 1'b0, 8'h00}) begin
            fails++; $display("FAIL reset_release got=%0h exp=%0h", {b.in_ready, b.out_valid, b.taken_count}, {1'b1, 1'b0, 8'h00});
        end
    endtask

    task automatic test_condition(input string name, input logic [15:0] x, input logic [15:0] y,
                                  input logic [2:0] m, input logic [15:0] pc, input logic [15:0] off,
                                  input logic e_neq, input logic e_lt, input logic e_ltu,
                                  input logic e_taken, input logic [15:0] e_target);
        logic [20:0] got;
        logic [20:0] exp;
        b.out_ready = 0;
        drive_b(x, y, m, pc, off);
        b.in_valid = 1;
        step();
        b.in_valid = 0;
        tests++;
        if (b.out_valid !== 1'b0) begin
            fails++; $display("FAIL %s_early_valid got=%0b exp=0", name, b.out_valid);
        end
        step();
        got = {b.out_valid, b.nEq, b.lt, b.ltu, b.taken, b.target};
        exp = {1'b1, e_neq, e_lt, e_ltu, e_taken, e_target};
        tests++;
        if (got !== exp) begin
            fails++; $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
        b.out_ready = 1;
        step();
        b.out_ready = 0;
        if (e_taken) exp_cnt++;
        tests++;
        if ({b.out_valid, b.taken_count} !== {1'b0, 8'(exp_cnt)}) begin
            fails++; $display("FAIL %s_drain got=%0h exp=%0h", name, {b.out_valid, b.taken_count}, {1'b0, 8'(exp_cnt)});
        end
    endtask

    task automatic test_conditions();
        test_condition("bne_equal",   16'h0005, 16'h0005, 3'b001, 16'h0010, 16'h0008, 0, 0, 0, 0, 16'h0018);
        test_condition("blt_signed",  16'h8000, 16'h0001, 3'b010, 16'h0000, 16'h0000, 1, 1, 0, 1, 16'h0000);
        test_condition("bltu_unsig",  16'h8000, 16'h0001, 3'b100, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0000);
        test_condition("bge_ovf",     16'h7FFF, 16'hFFFF, 3'b011, 16'h0000, 16'h0000, 1, 0, 1, 1, 16'h0000);
        test_condition("bge_neg",     16'hFFFF, 16'h0001, 3'b011, 16'h0020, 16'h0002, 1, 1, 0, 0, 16'h0022);
        test_condition("beq_wrap",    16'h1234, 16'h1234, 3'b000, 16'hFFFE, 16'h0004, 0, 0, 0, 1, 16'h0002);
        test_condition("bgeu_negoff", 16'h0003, 16'h0009, 3'b101, 16'h0004, 16'hFFF8, 1, 1, 1, 0, 16'hFFFC);
        test_condition("rsvd_110",    16'h0001, 16'h0002, 3'b110, 16'h0030, 16'h0000, 1, 1, 1, 0, 16'h0030);
        test_condition("rsvd_111",    16'h0004, 16'h0004, 3'b111, 16'h0040, 16'h0000, 0, 0, 0, 0, 16'h0040);
    endtask

    task automatic test_back_to_back();
        b.out_ready = 0;
        drive_b(16'd0, 16'd1, 3'b001, 16'h0100, 16'h0); b.in_valid = 1;
        tests++;
        if (b.in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready0 got=%0b exp=1", b.in_ready); end
        step();
        drive_b(16'd1, 16'd1, 3'b001, 16'h0110, 16'h0);
        step();
        drive_b(16'd2, 16'd1, 3'b001, 16'h0120, 16'h0);
        tests++;
        if ({b.in_ready, b.out_valid, b.target, b.taken} !== {1'b0, 1'b1, 16'h0100, 1'b1}) begin
            fails++; $display("FAIL bp_full got=%0h exp=%0h", {b.in_ready, b.out_valid, b.target, b.taken}, {1'b0, 1'b1, 16'h0100, 1'b1});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if ({b.in_ready, b.out_valid, b.target, b.taken, b.nEq} !== {1'b0, 1'b1, 16'h0100, 1'b1, 1'b1}) begin
                fails++; $display("FAIL bp_stall%0d got=%0h exp=%0h", i, {b.in_ready, b.out_valid, b.target, b.taken, b.nEq}, {1'b0, 1'b1, 16'h0100, 1'b1, 1'b1});
            end
        end
        b.out_ready = 1;
        #1;
        tests++;
        if (b.in_ready !== 1'b1) begin fails++; $display("FAIL bp_comb_ready got=%0b exp=1", b.in_ready); end
        step();
        tests++;
        if ({b.out_valid, b.target, b.taken} !== {1'b1, 16'h0110, 1'b0}) begin
            fails++; $display("FAIL bp_out1 got=%0h exp=%0h", {b.out_valid, b.target, b.taken}, {1'b1, 16'h0110, 1'b0});
        end
        drive_b(16'd3, 16'd1, 3'b001, 16'h0130, 16'h0);
        step();
        b.in_valid = 0;
        tests++;
        if ({b.out_valid, b.target, b.taken} !== {1'b1, 16'h0120, 1'b1}) begin
            fails++; $display("FAIL bp_out2 got=%0h exp=%0h", {b.out_valid, b.target, b.taken}, {1'b1, 16'h0120, 1'b1});
        end
        step();
        tests++;
        if ({b.out_valid, b.target, b.taken} !== {1'b1, 16'h0130, 1'b1}) begin
            fails++; $display("FAIL bp_out3 got=%0h exp=%0h", {b.out_valid, b.target, b.taken}, {1'b1, 16'h0130, 1'b1});
        end
        step();
        exp_cnt += 3;
        b.out_ready = 0;
        tests++;
        if ({b.out_valid, b.taken_count} !== {1'b0, 8'(exp_cnt)}) begin
            fails++; $display("FAIL bp_done got=%0h exp=%0h", {b.out_valid, b.taken_count}, {1'b0, 8'(exp_cnt)});
        end
    endtask

    task automatic test_flush();
        b.out_ready = 0;
        drive_b(16'd7, 16'd7, 3'b000, 16'h0200, 16'h0); b.in_valid = 1;
        step();
        drive_b(16'd9, 16'd9, 3'b000, 16'h0210, 16'h0);
        step();
        drive_b(16'd5, 16'd5, 3'b000, 16'h0220, 16'h0);
        b.flush = 1; b.out_ready = 1;
        step();
        b.flush = 0; b.in_valid = 0;
        exp_cnt++;
        tests++;
        if ({b.out_valid, b.taken_count} !== {1'b0, 8'(exp_cnt)}) begin
            fails++; $display("FAIL flush_clear got=%0h exp=%0h", {b.out_valid, b.taken_count}, {1'b0, 8'(exp_cnt)});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if ({b.out_valid, b.taken_count} !== {1'b0, 8'(exp_cnt)}) begin
                fails++; $display("FAIL flush_ghost%0d got=%0h exp=%0h", i, {b.out_valid, b.taken_count}, {1'b0, 8'(exp_cnt)});
            end
        end
        test_condition("after_flush", 16'h0002, 16'h0001, 3'b001, 16'h0300, 16'h0010, 1, 0, 0, 1, 16'h0310);
    endtask

    task automatic test_reset_mid();
        b.out_ready = 0;
        drive_b(16'd1, 16'd1, 3'b000, 16'h0400, 16'h0); b.in_valid = 1;
        step();
        step();
        b.in_valid = 0;
        tests++;
        if ({b.out_valid, b.in_ready} !== 2'b10) begin
            fails++; $display("FAIL rst_prefill got=%0b exp=10", {b.out_valid, b.in_ready});
        end
        #2;
        rst_n = 0;
        #1;
        exp_cnt = 0;
        tests++;
        if ({b.in_ready, b.out_valid, b.taken, b.target, b.nEq, b.lt, b.ltu, b.taken_count} !== 30'h0) begin
            fails++; $display("FAIL rst_async got=%0h exp=0", {b.in_ready, b.out_valid, b.taken, b.target, b.nEq, b.lt, b.ltu, b.taken_count});
        end
        @(negedge clk); rst_n = 1;
        step();
        tests++;
        if ({b.in_ready, b.out_valid, b.taken_count} !== {1'b1, 1'b0, 8'h00}) begin
            fails++; $display("FAIL rst_mid_release got=%0h exp=%0h", {b.in_ready, b.out_valid, b.taken_count}, {1'b1, 1'b0, 8'h00});
        end
    endtask

    task automatic test_saturation();
        s.out_ready = 1;
        drive_s(16'd3, 16'd3, 3'b001); s.in_valid = 1;
        step();
        s.in_valid = 0;
        repeat (2) step();
        tests++;
        if ({s.out_valid, s.taken_count} !== 4'b0000) begin
            fails++; $display("FAIL sat_nottaken got=%0h exp=0", {s.out_valid, s.taken_count});
        end
        s.out_ready = 0;
        drive_s(16'd1, 16'd1, 3'b000); s.in_valid = 1;
        step();
        s.in_valid = 0;
        repeat (3) step();
        tests++;
        if ({s.out_valid, s.taken, s.taken_count} !== {1'b1, 1'b1, 3'd0}) begin
            fails++; $display("FAIL sat_stalled got=%0h exp=%0h", {s.out_valid, s.taken, s.taken_count}, {1'b1, 1'b1, 3'd0});
        end
        s.out_ready = 1;
        step();
        tests++;
        if (s.taken_count !== 3'd1) begin fails++; $display("FAIL sat_first got=%0d exp=1", s.taken_count); end
        drive_s(16'h00AA, 16'h00AA, 3'b000); s.in_valid = 1;
        repeat (8) step();
        s.in_valid = 0;
        repeat (3) step();
        tests++;
        if (s.taken_count !== 3'd7) begin fails++; $display("FAIL sat_nine got=%0d exp=7", s.taken_count); end
        s.in_valid = 1;
        step();
        s.in_valid = 0;
        repeat (3) step();
        tests++;
        if ({s.out_valid, s.taken_count} !== {1'b0, 3'd7}) begin
            fails++; $display("FAIL sat_hold got=%0h exp=%0h", {s.out_valid, s.taken_count}, {1'b0, 3'd7});
        end
    endtask

    initial begin
        test_reset();
        test_conditions();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/branch_compare_unit.md
# branch_compare_unit

Parametrised, pipelined branch-resolution block for the processor datapath. It replaces the single-mode, combinational not-equal flag with a WIDTH-generic comparator that supports six branch conditions. It computes the branch target, passes results downstream through a two-stage valid/ready pipeline, and keeps a saturating count of taken branches. It sits between operand read and the PC-update logic.

## Interface
Parameters:
- WIDTH, 16, operand width of X and Y (≥2)
- PC_WIDTH, 16, width of pc, offset and target
- CNT_WIDTH, 8, width of taken_count

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous assert, active-low; all state cleared while low
- in_valid  input  1  request present on X/Y/mode/pc/offset
- in_ready  output  1  unit accepts request this cycle
- X  input  WIDTH  operand A
- Y  input  WIDTH  operand B
- mode  input  3  condition: 000 BEQ, 001 BNE, 010 BLT, 011 BGE, 100 BLTU, 101 BGEU, 110/111 reserved (never taken)
- pc  input  PC_WIDTH  address of the branch instruction
- offset  input  PC_WIDTH  two's-complement displacement
- flush  input  1  synchronous kill of all in-flight requests
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- taken  output  1  condition true
- target  output  PC_WIDTH  pc + offset, valid with out_valid
- nEq  output  1  X != Y
- lt  output  1  X < Y, signed
- ltu  output  1  X < Y, unsigned
- taken_count  output  CNT_WIDTH  saturating count of accepted taken results

## Operation
- Handshake: a request is accepted on any edge with in_valid && in_ready. A result is consumed on any edge with out_valid && out_ready.
- Stage 1 (S1) registers:
  - D = {1'b0,X} − {1'b0,Y}, WIDTH+1 bits
  - sign bits X[WIDTH-1] and Y[WIDTH-1]
  - mode
  - target = pc + offset, modulo 2^PC_WIDTH
- Stage 2 (S2) registers the flags and the decision:
  - nEq = |D[WIDTH-1:0]
  - ltu = D[WIDTH], the borrow
  - lt = D[WIDTH-1] XOR V, where V = (X sign ≠ Y sign) && (D[WIDTH-1] ≠ X sign)
  - taken is selected by mode: BEQ = !nEq, BNE = nEq, BLT = lt, BGE = !lt, BLTU = ltu, BGEU = !ltu, reserved = 0
- Stage movement:
  - S2 loads from S1 when S2 is empty or being consumed.
  - S1 loads from input when S1 is empty or moving to S2.
  - in_ready = !S1_valid || S2_load. It is combinational from out_ready and is never gated by in_valid.
- Back-pressure: S2 holds all output values stable while out_valid && !out_ready. Two requests can be held at once, one in each stage; no request is lost or duplicated.
- flush: on an edge with flush = 1, S1_valid and S2_valid clear.
  - A request accepted on that same edge is discarded.
  - A result consumed on that same edge still counts toward taken_count.
  - Data registers may keep stale values; only the valid bits are cleared.
- taken_count: increments by 1 on each edge with out_valid && out_ready && taken. It saturates at 2^CNT_WIDTH − 1 and has no wrap. It clears only on reset.
- Reset: all valids, flags, target and taken_count are 0. in_ready is 1 once rst_n is released. Asserting rst_n mid-operation drops every in-flight request immediately.

## Timing
- Latency: a request accepted at edge N gives out_valid = 1 after edge N+1, provided S2 was free.
- Throughput: one result per cycle while out_ready = 1.
- The outputs (taken, target, nEq, lt, ltu, taken_count) all come from registers. in_ready is the only combinational output.
- taken_count updates on the same edge as the consuming handshake.

## Test plan
- BNE, X=Y=16'h0005, pc=16'h0010, offset=16'h0008 -> after 2 edges: out_valid=1, nEq=0, taken=0, target=16'h0018.
- Signed vs unsigned, X=16'h8000, Y=16'h0001:
  - BLT -> lt=1, taken=1
  - BLTU -> ltu=0, taken=0
  - Also X=16'h7FFF, Y=16'hFFFF, BGE -> taken=1, which checks overflow handling of lt.
- Target wrap: pc=16'hFFFE, offset=16'h0004 -> target=16'h0002. Negative offset: pc=16'h0004, offset=16'hFFF8 -> target=16'hFFFC.
- Back-pressure: hold out_ready=0 while streaming 4 requests.
  - in_ready drops after 2 accepts.
  - Outputs stay stable while stalled.
  - After out_ready=1, all 4 results emerge in order, one per cycle.
- Flush and reset: fill both stages, then pulse flush with in_valid=1.
  - Next cycle: out_valid=0, and the request sent during flush never appears.
  - Repeat, but drop rst_n mid-stream: all outputs read 0 asynchronously.
- Counter saturation, CNT_WIDTH=3: issue 9 taken BEQ requests (X=Y) -> taken_count reaches 7 and stays 7. A not-taken result or a taken result with out_ready=0 leaves the count unchanged.
